// File: rtl/iob_eth_ram_byte_writer.sv
// iob_eth_ram_byte_writer: packs an RX byte stream little-endian into RAM words and writes them from a base address.
module iob_eth_ram_byte_writer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BCNT_W = ADDR_W + $clog2(DATA_W/8) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_data_i,
  input  logic                byte_last_i,
  output logic                byte_ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [BCNT_W-1:0]   byte_count_o,
  output logic                overflow_o,
  output logic [DATA_W/8-1:0] ram_w_strb_o,
  output logic [ADDR_W-1:0]   ram_w_addr_o,
  output logic [DATA_W-1:0]   ram_w_data_o
);
  localparam int NB = DATA_W / 8;
  localparam int LW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] pack_q, pack_d, pack_n, data_q, data_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [NB-1:0] strb_q, strb_d, strb_n;
  logic ovf_q, ovf_d, done_q, done_d;
  logic acc, full, store, wr;
  // Capacity is exactly 2^(BCNT_W-1) bytes, so the counter MSB flags a full buffer.
  assign full  = cnt_q[BCNT_W-1];
  assign acc   = byte_valid_i & byte_ready_o;
  assign store = acc & ~full;
  assign wr    = store & ((lane_q == LW'(NB-1)) | byte_last_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = start_i ? RECV : (state_q == RECV && acc && byte_last_i) ? IDLE : state_q;
  end
  always_comb begin
    byte_ready_o = (state_q == RECV) & ~start_i;
    busy_o       = state_q == RECV;
  end
  always_comb begin
    pack_n = pack_q;
    pack_n[{lane_q, 3'b000} +: 8] = byte_data_i;
    strb_n = '0;
    for (int i = 0; i < NB; i++) strb_n[i] = LW'(i) <= lane_q;
  end
  always_comb begin
    ptr_d  = ptr_q;
    lane_d = lane_q;
    pack_d = pack_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    strb_d = '0;
    addr_d = '0;
    data_d = '0;
    done_d = acc & byte_last_i;
    if (start_i) begin
      ptr_d  = base_addr_i;
      lane_d = '0;
      pack_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (acc && full) begin
      ovf_d = 1'b1;
    end else if (store) begin
      cnt_d = cnt_q + 1'b1;
      if (wr) begin
        strb_d = strb_n;
        addr_d = ptr_q;
        data_d = pack_n;
        ptr_d  = ptr_q + 1'b1;
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        pack_d = pack_n;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      lane_q <= '0;
      pack_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      strb_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lane_q <= lane_d;
      pack_q <= pack_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      strb_q <= strb_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end
  assign done_o       = done_q;
  assign byte_count_o = cnt_q;
  assign overflow_o   = ovf_q;
  assign ram_w_strb_o = strb_q;
  assign ram_w_addr_o = addr_q;
  assign ram_w_data_o = data_q;
endmodule
